// File: rtl/dl_pkg.sv
// Shared helpers for the dl_pipe_vr pipeline family.
package dl_pkg;

  // Bits needed to count 0..n, never less than one.
  function automatic int dl_occ_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dl_pipe_vr_stage.sv
// One valid/data slot of the pipeline; accepts upstream whenever empty or draining.
module dl_pipe_vr_stage
  import dl_pkg::*;
#(
  parameter int                  NUM_BITS = 32,
  parameter logic [NUM_BITS-1:0] RST_VAL  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                up_valid,
  input  logic [NUM_BITS-1:0] up_data,
  input  logic                dn_ready,
  output logic                up_ready,
  output logic                valid,
  output logic [NUM_BITS-1:0] data
);

  logic                v_q, v_d;
  logic [NUM_BITS-1:0] d_q, d_d;

  assign up_ready = !v_q || dn_ready;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = 1'b0;
      d_d = RST_VAL;
    end else if (up_ready) begin
      v_d = up_valid;
      if (up_valid) d_d = up_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      d_q <= RST_VAL;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign valid = v_q;
  assign data  = d_q;

endmodule

// File: rtl/dl_pipe_vr.sv
// Multi-stage valid/ready pipeline register with bubble collapsing and flush.
// Define DL_PIPE_VR_OCC_EN to add the registered occupancy output occ.
module dl_pipe_vr
  import dl_pkg::*;
#(
  parameter int                  NUM_BITS   = 32,
  parameter int                  NUM_STAGES = 2,
  parameter logic [NUM_BITS-1:0] RST_VAL    = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] out_data
`ifdef DL_PIPE_VR_OCC_EN
  ,
  output logic [dl_occ_width(NUM_STAGES)-1:0] occ
`endif
);

  // Index 0 is the producer side; index i+1 is the output of stage i.
  logic [NUM_STAGES:0]               vld_pipe;
  logic [NUM_STAGES:0][NUM_BITS-1:0] dat_pipe;
  logic [NUM_STAGES:0]               rdy;

  assign vld_pipe[0]     = in_valid;
  assign dat_pipe[0]     = in_data;
  assign rdy[NUM_STAGES] = out_ready;

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stg
    dl_pipe_vr_stage #(
      .NUM_BITS (NUM_BITS),
      .RST_VAL  (RST_VAL)
    ) u_stg (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .up_valid (vld_pipe[i]),
      .up_data  (dat_pipe[i]),
      .dn_ready (rdy[i+1]),
      .up_ready (rdy[i]),
      .valid    (vld_pipe[i+1]),
      .data     (dat_pipe[i+1])
    );
  end

  // Flush blocks both handshakes for the cycle it is asserted.
  assign in_ready  = rdy[0] && !flush;
  assign out_valid = vld_pipe[NUM_STAGES] && !flush;
  assign out_data  = dat_pipe[NUM_STAGES];

`ifdef DL_PIPE_VR_OCC_EN
  localparam int OW = dl_occ_width(NUM_STAGES);

  logic          push, pop;
  logic [OW-1:0] occ_q, occ_d;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Internal bubble collapsing never changes the count; only the two ends do.
  always_comb begin
    occ_d = occ_q;
    if (flush)             occ_d = '0;
    else if (push && !pop) occ_d = occ_q + OW'(1);
    else if (pop && !push) occ_d = occ_q - OW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_dl_pipe_vr.sv
// Directed and scoreboard checks for dl_pipe_vr (2-stage and 3-stage instances).
module tb_dl_pipe_vr;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  // Instance A: 2 stages, non-zero reset value.
  logic        a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic        a_in_ready, a_out_valid;
  logic [31:0] a_in_data = '0, a_out_data;
  // Instance B: 3 stages, zero reset value.
  logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_in_data = '0, b_out_data;
`ifdef DL_PIPE_VR_OCC_EN
  logic [1:0]  a_occ, b_occ;
`endif

  dl_pipe_vr #(.NUM_BITS(32), .NUM_STAGES(2), .RST_VAL(32'hdeadbeef)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
`ifdef DL_PIPE_VR_OCC_EN
    , .occ(a_occ)
`endif
  );

  dl_pipe_vr #(.NUM_BITS(32), .NUM_STAGES(3), .RST_VAL(32'h0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
`ifdef DL_PIPE_VR_OCC_EN
    , .occ(b_occ)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive at the falling edge, sample 1ns later.
  task automatic nxt();
    @(negedge clk);
  endtask

  logic [31:0] sb[$];

  initial begin
    // ---- asynchronous reset from power-up ----
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a_valid", {31'b0, a_out_valid}, 32'd0);
    chk("rst_a_data", a_out_data, 32'hdeadbeef);
    chk("rst_a_in_ready", {31'b0, a_in_ready}, 32'd1);
    chk("rst_b_data", b_out_data, 32'h0);
    nxt(); nxt();
    rst_n = 1'b1;

    // ---- reset mid-stall (A) ----
    a_in_valid = 1'b1; a_in_data = 32'h11;
    nxt(); a_in_valid = 1'b0;
    nxt(); #1;
    chk("stall_a_valid", {31'b0, a_out_valid}, 32'd1);
    chk("stall_a_data", a_out_data, 32'h11);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, a_out_valid}, 32'd0);
    chk("midrst_data", a_out_data, 32'hdeadbeef);
    nxt(); rst_n = 1'b1; a_out_ready = 1'b1;
    nxt(); #1;
    chk("postrst_valid", {31'b0, a_out_valid}, 32'd0);

    // ---- backpressure (A, 2 stages) ----
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'hA; #1;
    chk("bp_rdy_A", {31'b0, a_in_ready}, 32'd1);
    nxt(); a_in_data = 32'hB; #1;
    chk("bp_rdy_B", {31'b0, a_in_ready}, 32'd1);
    nxt(); a_in_data = 32'hC; #1;
    chk("bp_rdy_C", {31'b0, a_in_ready}, 32'd0);
    chk("bp_out_valid", {31'b0, a_out_valid}, 32'd1);
    chk("bp_out_hold", a_out_data, 32'hA);
`ifdef DL_PIPE_VR_OCC_EN
    chk("bp_occ_full", {30'b0, a_occ}, 32'd2);
`endif
    nxt(); #1;
    chk("bp_stable", a_out_data, 32'hA);
    a_out_ready = 1'b1; #1;
    chk("bp_rdy_chain", {31'b0, a_in_ready}, 32'd1);
    nxt(); a_in_valid = 1'b0; #1;
    chk("bp_out_B", a_out_data, 32'hB);
    nxt(); #1;
    chk("bp_out_C", a_out_data, 32'hC);
    chk("bp_out_C_v", {31'b0, a_out_valid}, 32'd1);
    nxt(); #1;
    chk("bp_no_dup", {31'b0, a_out_valid}, 32'd0);

    // ---- flush on a full pipe (A) ----
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'h21;
    nxt(); a_in_data = 32'h22;
    nxt(); a_flush = 1'b1; a_out_ready = 1'b1; a_in_data = 32'h23; #1;
    chk("fl_out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("fl_in_ready", {31'b0, a_in_ready}, 32'd0);
`ifdef DL_PIPE_VR_OCC_EN
    chk("fl_occ_before", {30'b0, a_occ}, 32'd2);
`endif
    nxt(); a_flush = 1'b0; a_in_valid = 1'b0; #1;
    chk("fl_after_valid", {31'b0, a_out_valid}, 32'd0);
    chk("fl_after_ready", {31'b0, a_in_ready}, 32'd1);
    chk("fl_after_data", a_out_data, 32'hdeadbeef);
`ifdef DL_PIPE_VR_OCC_EN
    chk("fl_occ_after", {30'b0, a_occ}, 32'd0);
`endif

    // ---- streaming (B, 3 stages) ----
    b_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      b_in_valid = (k < 4);
      b_in_data  = 32'(k + 1);
      #1;
      if (k < 3 || k == 7) chk($sformatf("st_empty_%0d", k), {31'b0, b_out_valid}, 32'd0);
      else begin
        chk($sformatf("st_valid_%0d", k), {31'b0, b_out_valid}, 32'd1);
        chk($sformatf("st_data_%0d", k), b_out_data, 32'(k - 2));
      end
      nxt();
    end
    b_in_valid = 1'b0;

    // ---- bubble collapse (B) ----
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 32'h5;
    nxt(); b_in_valid = 1'b0;
    nxt(); nxt(); #1;
    chk("bub_out_5", b_out_data, 32'h5);
    chk("bub_out_v", {31'b0, b_out_valid}, 32'd1);
    b_in_valid = 1'b1; b_in_data = 32'h6; #1;
    chk("bub_acc_6", {31'b0, b_in_ready}, 32'd1);
    nxt(); b_in_data = 32'h7; #1;
    chk("bub_acc_7", {31'b0, b_in_ready}, 32'd1);
    nxt(); b_in_valid = 1'b0; #1;
    chk("bub_full", {31'b0, b_in_ready}, 32'd0);
`ifdef DL_PIPE_VR_OCC_EN
    chk("bub_occ", {30'b0, b_occ}, 32'd3);
`endif
    b_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bub_drain_%0d", k), b_out_data, 32'(5 + k));
      nxt();
    end
    #1;
    chk("bub_empty", {31'b0, b_out_valid}, 32'd0);

    // ---- random soak (A) against a queue scoreboard ----
    sb.delete();
    for (int k = 0; k < 400; k++) begin
      nxt();
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_in_data   = $urandom;
      a_out_ready = ($urandom_range(0, 2) != 0);
      a_flush     = ($urandom_range(0, 30) == 0);
      #1;
`ifdef DL_PIPE_VR_OCC_EN
      chk("soak_occ", {30'b0, a_occ}, 32'(sb.size()));
`endif
      if (a_flush) begin
        chk("soak_fl_v", {31'b0, a_out_valid}, 32'd0);
        chk("soak_fl_r", {31'b0, a_in_ready}, 32'd0);
        sb.delete();
      end else begin
        if (a_out_valid && a_out_ready) begin
          if (sb.size() == 0) chk("soak_spurious", 32'd1, 32'd0);
          else begin
            chk("soak_data", a_out_data, sb[0]);
            void'(sb.pop_front());
          end
        end
        if (a_in_valid && a_in_ready) sb.push_back(a_in_data);
      end
    end
    nxt();
    a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (a_out_valid) begin
        if (sb.size() == 0) chk("drain_spurious", 32'd1, 32'd0);
        else begin
          chk("drain_data", a_out_data, sb[0]);
          void'(sb.pop_front());
        end
      end
      nxt();
    end
    chk("drain_left", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
